// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the multi-mode ring/Johnson counter.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  // Start (reset) pattern of a mode, LSB-aligned; callers truncate to WIDTH.
  function automatic logic [31:0] start_pattern(input logic mode);
    return (mode == MODE_RING) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/ring_pattern_check.sv
// Combinational legality check of a pattern for a given mode, plus the
// sequence position that pattern corresponds to (meaningful only if legal).
module ring_pattern_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int POSW  = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] pattern,
  input  logic             mode,
  output logic             legal,
  output logic [POSW-1:0]  pos_of
);

  logic [WIDTH-1:0] inv;
  logic             low_run;
  logic             high_run;

  // Popcount / set-bit index, then classify against the mode's legal shapes.
  always_comb begin
    int unsigned ones;
    int unsigned idx;
    ones     = 0;
    idx      = 0;
    legal    = 1'b0;
    pos_of   = '0;
    inv      = ~pattern;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pattern[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    // 0..01..1 has no carry overlap with itself+1; 1..10..0 is the same test on the inverse.
    low_run  = ((pattern & (pattern + WIDTH'(1))) == '0);
    high_run = ((inv & (inv + WIDTH'(1))) == '0);
    if (mode == MODE_RING) begin
      legal  = (ones == 1);
      pos_of = POSW'(idx);
    end else begin
      legal  = low_run || high_run;
      if (pattern[0] || (pattern == '0))
        pos_of = POSW'(ones);
      else
        pos_of = POSW'(2*WIDTH - ones);
    end
  end

endmodule

// File: rtl/ring_counter_mm.sv
// Parametrised ring / Johnson shift counter with direction, enable and
// validated parallel load. Optional macro RING_SELF_CORRECT_EN adds a
// per-cycle legality/consistency check of the registered state.
module ring_counter_mm
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int POSW  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [POSW-1:0]  pos,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [POSW-1:0]  pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             mode_q, mode_d;
  logic [POSW-1:0]  last;
  logic             ld_legal;
  logic [POSW-1:0]  ld_pos;

  ring_pattern_check #(.WIDTH(WIDTH), .POSW(POSW)) u_load_check (
    .pattern (load_val),
    .mode    (mode_q),
    .legal   (ld_legal),
    .pos_of  (ld_pos)
  );

`ifdef RING_SELF_CORRECT_EN
  logic            st_legal;
  logic [POSW-1:0] st_pos;
  logic            st_ok;

  ring_pattern_check #(.WIDTH(WIDTH), .POSW(POSW)) u_state_check (
    .pattern (out_q),
    .mode    (mode_q),
    .legal   (st_legal),
    .pos_of  (st_pos)
  );

  assign st_ok = st_legal && (st_pos == pos_q);
`endif

  // Next-state selection: mode change, (correction), load, step, hold.
  always_comb begin
    out_d  = out_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    mode_d = mode_q;
    last   = (mode_q == MODE_JOHNSON) ? POSW'(2*WIDTH - 1) : POSW'(WIDTH - 1);
    if (mode != mode_q) begin
      mode_d = mode;
      out_d  = WIDTH'(start_pattern(mode));
      pos_d  = '0;
    end
`ifdef RING_SELF_CORRECT_EN
    else if (!st_ok) begin
      out_d = WIDTH'(start_pattern(mode_q));
      pos_d = '0;
      err_d = 1'b1;
    end
`endif
    else if (load) begin
      if (ld_legal) begin
        out_d = load_val;
        pos_d = ld_pos;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      // Ring and Johnson share one shifter: the feedback bit is inverted only in Johnson mode.
      if (dir == DIR_LEFT) begin
        out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ mode_q};
        pos_d = (pos_q == last) ? '0 : pos_q + POSW'(1);
      end else begin
        out_d = {out_q[0] ^ mode_q, out_q[WIDTH-1:1]};
        pos_d = (pos_q == '0) ? last : pos_q - POSW'(1);
      end
      wrap_d = (pos_d == '0);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= WIDTH'(start_pattern(mode));
      pos_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= mode;
    end else begin
      out_q  <= out_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      mode_q <= mode_d;
    end
  end

  assign out  = out_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ring_counter_mm.sv
// Self-checking bench for ring_counter_mm (WIDTH=4): directed scenarios with
// constant expectations plus randomized traffic against a position-based model.
module tb_ring_counter_mm;

  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          reset, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  out;
  logic [PW-1:0] pos;
  logic          wrap, err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: the pattern is a pure function of (mode, position).
  logic         m_mode;
  int           m_pos;
  logic [W-1:0] m_out;
  logic         m_wrap, m_err;

  ring_counter_mm #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .out(out), .pos(pos), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int period(input logic md);
    return md ? 2*W : W;
  endfunction

  function automatic logic [W-1:0] pat_at(input logic md, input int p);
    if (!md) return W'(1) << p;
    if (p <= W) return W'((1 << p) - 1);
    return ~W'((1 << (p - W)) - 1);
  endfunction

  function automatic int find_pos(input logic md, input logic [W-1:0] v);
    for (int p = 0; p < period(md); p++)
      if (pat_at(md, p) == v) return p;
    return -1;
  endfunction

  task automatic model_update();
    int p;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (!reset) begin
      m_mode = mode; m_pos = 0;
    end else if (mode != m_mode) begin
      m_mode = mode; m_pos = 0;
    end else if (load) begin
      p = find_pos(m_mode, load_val);
      if (p >= 0) m_pos = p;
      else m_err = 1'b1;
    end else if (en) begin
      if (!dir) m_pos = (m_pos + 1) % period(m_mode);
      else      m_pos = (m_pos + period(m_mode) - 1) % period(m_mode);
      m_wrap = (m_pos == 0);
    end
    m_out = pat_at(m_mode, m_pos);
  endtask

  // Advance one clock, update the model, sample #1 after the edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic md,
                       input logic ld, input logic [W-1:0] lv);
    reset = r; en = e; dir = d; mode = md; load = ld; load_val = lv;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100);
    repeat (2) begin
      cycle();
      n_cmp++;
      if ({out, pos, wrap, err} !== {4'b0001, 3'd0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset: out=%b pos=%0d wrap=%b err=%b want out=0001 pos=0 wrap=0 err=0", out, pos, wrap, err);
      end
    end
  endtask

  task automatic test_ring_left();
    logic [W-1:0]  eo [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [PW-1:0] ep [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic          ew [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if ({out, pos, wrap, err} !== {eo[i], ep[i], ew[i], 1'b0}) begin
        n_bad++;
        $display("FAIL ring_left[%0d]: out=%b pos=%0d wrap=%b err=%b want %b/%0d/%b/0", i, out, pos, wrap, err, eo[i], ep[i], ew[i]);
      end
    end
  endtask

  task automatic test_johnson_left();
    logic [W-1:0] eo [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    n_cmp++;
    if ({out, pos} !== {4'b0000, 3'd0}) begin
      n_bad++;
      $display("FAIL johnson_reset: out=%b pos=%0d want 0000/0", out, pos);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_cmp++;
      if ({out, pos, wrap} !== {eo[i], 3'((i + 1) % 8), (i == 7)}) begin
        n_bad++;
        $display("FAIL johnson_left[%0d]: out=%b pos=%0d wrap=%b want %b/%0d/%b", i, out, pos, wrap, eo[i], (i + 1) % 8, (i == 7));
      end
    end
  endtask

  task automatic test_ring_right_hold();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    n_cmp++;
    if ({out, pos, wrap} !== {4'b1000, 3'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL ring_right: out=%b pos=%0d wrap=%b want 1000/3/0", out, pos, wrap);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) begin
      cycle();
      n_cmp++;
      if ({out, pos, wrap} !== {4'b1000, 3'd3, 1'b0}) begin
        n_bad++;
        $display("FAIL hold: out=%b pos=%0d wrap=%b want 1000/3/0", out, pos, wrap);
      end
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110);
    cycle();
    n_cmp++;
    if ({out, pos, err} !== {4'b1110, 3'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL load_johnson: out=%b pos=%0d err=%b want 1110/5/0", out, pos, err);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010);
    cycle();
    n_cmp++;
    if ({out, pos, err} !== {4'b1110, 3'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL load_illegal: out=%b pos=%0d err=%b want 1110/5/1", out, pos, err);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    n_cmp++;
    if ({out, err} !== {4'b1110, 1'b0}) begin
      n_bad++;
      $display("FAIL err_pulse: out=%b err=%b want 1110/0", out, err);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    cycle();
    n_cmp++;
    if ({out, pos, err} !== {4'b1111, 3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL load_all_ones: out=%b pos=%0d err=%b want 1111/4/0", out, pos, err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    cycle();
    n_cmp++;
    if ({out, pos, err} !== {4'b0001, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL load_ring_zero: out=%b pos=%0d err=%b want 0001/0/1", out, pos, err);
    end
  endtask

  task automatic test_mode_change();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111);
    cycle();
    n_cmp++;
    if ({out, pos, wrap, err} !== {4'b0000, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL mode_change: out=%b pos=%0d wrap=%b err=%b want 0000/0/0/0", out, pos, wrap, err);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    repeat (3) cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001);
    cycle();
    n_cmp++;
    if ({out, pos, wrap, err} !== {4'b0000, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: out=%b pos=%0d wrap=%b err=%b want 0000/0/0/0", out, pos, wrap, err);
    end
  endtask

  task automatic test_random();
    logic md, ld;
    drive(1'b0, 1'b0, 1'b0, 1'(($urandom % 2)), 1'b0, '0);
    cycle();
    for (int i = 0; i < 400; i++) begin
      md = ($urandom_range(0, 19) == 0) ? ~m_mode : m_mode;
      ld = ($urandom_range(0, 4) == 0);
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 7), 1'(($urandom % 2)), md, ld,
            ($urandom % 2) ? pat_at(m_mode, int'($urandom_range(0, period(m_mode) - 1))) : W'($urandom));
      cycle();
      n_cmp++;
      if ({out, pos, wrap, err} !== {m_out, PW'(m_pos), m_wrap, m_err}) begin
        n_bad++;
        $display("FAIL random[%0d]: out=%b pos=%0d wrap=%b err=%b want %b/%0d/%b/%b", i, out, pos, wrap, err, m_out, m_pos, m_wrap, m_err);
      end
    end
  endtask

  task automatic test_force();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    force dut.out_q = 4'b0110;
    #1;
    release dut.out_q;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    n_cmp++;
`ifdef RING_SELF_CORRECT_EN
    if ({out, pos, err} !== {4'b0001, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL self_correct: out=%b pos=%0d err=%b want 0001/0/1", out, pos, err);
    end
`else
    if ({out, err} !== {4'b1100, 1'b0}) begin
      n_bad++;
      $display("FAIL illegal_propagate: out=%b err=%b want 1100/0", out, err);
    end
`endif
  endtask

  initial begin
    m_mode = 1'b0; m_pos = 0; m_out = 4'b0001; m_wrap = 1'b0; m_err = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    test_reset();
    test_ring_left();
    test_johnson_left();
    test_ring_right_hold();
    test_load();
    test_mode_change();
    test_random();
    test_force();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ring_counter_mm.md
Name: ring_counter_mm

Overview:
- Parametrised multi-mode shift counter; successor to the fixed 4-bit ring counter.
- Supports ring (one-hot) and Johnson (twisted-ring) modes, rotation in either direction, step enable and validated parallel load.
- Outputs the current pattern, a position index and a wrap pulse.
- Used as a sequencer and phase generator in datapath control blocks.

Parameters:
- WIDTH, 4: pattern width in bits, legal range 2 to 32. Period is WIDTH in ring mode and 2*WIDTH in Johnson mode.
- POSW, $clog2(2*WIDTH): width of the position index.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (0 = in reset)
- en  input  1  step enable
- dir  input  1  0 = shift left (toward MSB), 1 = shift right
- mode  input  1  0 = ring, 1 = Johnson
- load  input  1  parallel-load request
- load_val  input  WIDTH  pattern to load
- out  output  WIDTH  current pattern (registered)
- pos  output  POSW  position in sequence, 0 = start pattern (registered)
- wrap  output  1  1-cycle pulse when a step lands on the start pattern (registered)
- err  output  1  1-cycle pulse on a rejected load or, with the macro, a corrected state (registered)

Behaviour:
- All state is updated only on rising clk. Priority per cycle: reset, then mode change, then load, then step.
- Reset (reset==0 at an edge):
  - out = start pattern of the sampled mode: ring 0..01, Johnson 0..00.
  - pos = 0, wrap = 0, err = 0.
  - mode_q is loaded from mode.
- Mode change (mode != mode_q):
  - out = start pattern of the new mode, pos = 0, mode_q = mode, wrap = 0.
  - load and en are ignored that cycle.
- Load (load==1):
  - load_val is checked for legality in mode_q:
    - ring: exactly one bit set.
    - Johnson: of the form 0..01..1 or 1..10..0 (all-zero and all-one are legal).
  - Legal load: out = load_val; wrap = 0.
    - Ring: pos = index of the set bit.
    - Johnson: pos = popcount if load_val[0]==1 or load_val==0, else 2*WIDTH - popcount.
  - Illegal load: out and pos hold; err = 1 for one cycle.
  - Load works independently of en.
- Step (en==1, no load, no mode change):
  - Ring, left: out = {out[W-2:0], out[W-1]}. Ring, right: out = {out[0], out[W-1:1]}.
  - Johnson, left: out = {out[W-2:0], ~out[W-1]}. Johnson, right: out = {~out[0], out[W-1:1]}.
  - pos: left = (pos+1) mod period; right = (pos-1) mod period. pos 0 stepping right wraps to period-1.
  - wrap = 1 in the cycle after the step iff the new pos == 0, in either direction.
- en==0 with no load: out and pos hold; wrap = 0.
- wrap and err are plain registered pulses, cleared every cycle they are not re-set.
- dir may change on any cycle; it takes effect on the next step, with no glitch and no reinitialisation.
- Reset asserted mid-sequence or mid-load aborts the operation; reset values apply on the next edge.
- Latency: every input takes effect in out/pos/wrap/err one clock after sampling.

Optional Feature:
- Macro: RING_SELF_CORRECT_EN.
- Defined: every cycle the registered out is checked for legality against mode_q and for consistency with pos.
  - On any violation (e.g. multi-hot from an SEU or a forced value): next cycle out = start pattern, pos = 0, err = 1.
  - This check has priority over load and step.
- Undefined: no checking. An illegal state propagates through the shift rules unchanged; err is driven only by rejected loads.

Decomposition:
- Package ring_counter_pkg:
  - MODE_RING = 1'b0, MODE_JOHNSON = 1'b1, DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
  - Function start_pattern(mode) returning the reset pattern.
- Sub-module ring_pattern_check: combinational; inputs pattern and mode; outputs legal and pos_of.
  - One instance validates load_val.
  - A second instance, under the macro only, checks out.

Test Plan:
- WIDTH=4, mode=0, reset low 2 cycles then high, en=1, dir=0 -> out 0001,0010,0100,1000,0001; pos 0,1,2,3,0; wrap pulses once, on the 0001 return.
- mode=1, dir=0, 8 steps from reset -> out 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap at the final 0000.
- Ring at out=0001, dir=1, one step -> out 1000, pos 3, no wrap. Then en=0 for 3 cycles -> out holds 1000.
- Johnson, load load_val=1110 -> out 1110, pos 5. Then load 1010 -> out holds, err pulses 1 cycle. Ring, load 0000 -> err.
- Running ring at 0100, toggle mode to 1 while load=1 -> out 0000, pos 0, load ignored. Reset low mid-sequence -> out 0000, pos 0 next edge.
- With RING_SELF_CORRECT_EN defined, force out=0110 in ring mode for one cycle, then release -> next cycle out 0001, pos 0, err 1. Without the macro -> out shifts to 1100 and err stays 0.
